// File: rtl/ps2_dir_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_dir_decoder
// Description : PS/2 device-to-host receiver with arrow/WASD direction decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_dir_decoder #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TW             = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down,
    output logic [1:0] dir,
    output logic       dir_valid
);

    localparam logic [TW-1:0] c_TIMEOUT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_clk_prev;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_sh;
    logic          r_par;
    logic [TW-1:0] r_to;
    logic [7:0]    r_code;
    logic          r_code_valid, r_frame_err;
    logic          r_ext, r_brk;
    logic [7:0]    r_held;
    logic [1:0]    r_dir;
    logic          r_dir_valid;

    logic          w_fall, w_dat, w_timeout, w_good, w_bad;
    logic          w_hit;
    logic [1:0]    w_key_dir;

    assign w_fall    = r_clk_prev & ~r_clk_sync[1];
    assign w_dat     = r_dat_sync[1];
    assign w_timeout = (r_state != S_IDLE) && (r_to == c_TIMEOUT);

    // Both pins idle high, so the synchronisers reset to 1 to avoid a fake edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[0], PS2_DAT};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_bad       = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_dat) w_state_nxt = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (w_dat && ((^r_sh) ^ r_par)) w_good = 1'b1;
                    else                            w_bad  = 1'b1;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitcnt     <= 3'd0;
            r_sh         <= 8'd0;
            r_par        <= 1'b0;
            r_to         <= '0;
            r_code       <= 8'd0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= w_good;
            r_frame_err  <= w_bad;
            if (w_good) r_code <= r_sh;

            if (r_state == S_IDLE || w_fall) r_to <= '0;
            else                             r_to <= r_to + 1'b1;

            if (w_fall && !w_timeout) begin
                case (r_state)
                    S_IDLE:   r_bitcnt <= 3'd0;
                    S_DATA: begin
                        r_sh     <= {w_dat, r_sh[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: r_par <= w_dat;
                    default:  ;
                endcase
            end
        end
    end

    // Held-bit index is {~ext, dir}: arrows occupy 0..3, WASD occupy 4..7.
    always_comb begin
        w_hit     = 1'b0;
        w_key_dir = 2'd0;
        if (r_ext) begin
            case (r_code)
                8'h6B: begin w_hit = 1'b1; w_key_dir = 2'd0; end
                8'h74: begin w_hit = 1'b1; w_key_dir = 2'd1; end
                8'h75: begin w_hit = 1'b1; w_key_dir = 2'd2; end
                8'h72: begin w_hit = 1'b1; w_key_dir = 2'd3; end
                default: ;
            endcase
        end else begin
            case (r_code)
                8'h1C: begin w_hit = 1'b1; w_key_dir = 2'd0; end
                8'h23: begin w_hit = 1'b1; w_key_dir = 2'd1; end
                8'h1D: begin w_hit = 1'b1; w_key_dir = 2'd2; end
                8'h1B: begin w_hit = 1'b1; w_key_dir = 2'd3; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_held      <= 8'd0;
            r_dir       <= 2'd1;
            r_dir_valid <= 1'b0;
        end else begin
            r_dir_valid <= 1'b0;
            if (r_code_valid) begin
                if (r_code == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_code == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (w_hit) begin
                        r_held[{~r_ext, w_key_dir}] <= ~r_brk;
                        if (!r_brk) begin
                            r_dir       <= w_key_dir;
                            r_dir_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign code       = r_code;
    assign code_valid = r_code_valid;
    assign frame_err  = r_frame_err;
    assign left       = r_held[0] | r_held[4];
    assign right      = r_held[1] | r_held[5];
    assign up         = r_held[2] | r_held[6];
    assign down       = r_held[3] | r_held[7];
    assign dir        = r_dir;
    assign dir_valid  = r_dir_valid;

endmodule
`default_nettype wire
